// File: rtl/ram_wr_pkg.sv
// Shared types and default widths for the RAM write sequencer.
package ram_wr_pkg;

    localparam int RAM_ADDR_W       = 8;
    localparam int RAM_DATA_W       = 8;
    localparam int RAM_MAX_READ_LAT = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_CHECK = 3'd3,
        ST_HOLD  = 3'd4
    } ram_wr_state_t;

endpackage

// File: rtl/ram_wr_seq.sv
// One RAM write per button press, with optional readback check.
// Readback is built only when RAM_WR_SEQ_VERIFY_EN is defined.
module ram_wr_seq
    import ram_wr_pkg::*;
#(
    parameter int ADDR_W   = RAM_ADDR_W,
    parameter int DATA_W   = RAM_DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_en,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              err_any,
    output logic [7:0]        wr_count
);

    generate
        if (READ_LAT < 1 || READ_LAT > RAM_MAX_READ_LAT) begin : g_bad_read_lat
            $error("ram_wr_seq: READ_LAT must be in 1..3");
        end
    endgenerate

    ram_wr_state_t     state_reg, state_next;
    logic [ADDR_W-1:0] cap_addr_reg;
    logic [DATA_W-1:0] cap_data_reg;
    logic              done_reg;
    logic [7:0]        wr_count_reg;
    logic              capture;
    logic              complete;

`ifdef RAM_WR_SEQ_VERIFY_EN
    localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

    logic [1:0] cnt_reg, cnt_next;
    logic       err_reg, err_any_reg;
    logic       mismatch;

    assign mismatch = (ram_rdata != cap_data_reg);
`endif

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        complete   = 1'b0;
`ifdef RAM_WR_SEQ_VERIFY_EN
        cnt_next   = cnt_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (req_en) begin
                    capture    = 1'b1;
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
`ifdef RAM_WR_SEQ_VERIFY_EN
                // With single-cycle latency the data is already valid next cycle.
                cnt_next   = LAT_M1;
                state_next = (LAT_M1 == 2'd0) ? ST_CHECK : ST_READ;
`else
                complete   = 1'b1;
                state_next = ST_HOLD;
`endif
            end
`ifdef RAM_WR_SEQ_VERIFY_EN
            ST_READ: begin
                cnt_next = cnt_reg - 2'd1;
                if (cnt_reg <= 2'd1) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                complete   = 1'b1;
                state_next = ST_HOLD;
            end
`endif
            ST_HOLD: begin
                if (!req_en) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cap_addr_reg <= '0;
            cap_data_reg <= '0;
            done_reg     <= 1'b0;
            wr_count_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            done_reg  <= complete;
            if (capture) begin
                cap_addr_reg <= req_addr;
                cap_data_reg <= req_data;
            end
            if (complete) begin
                wr_count_reg <= wr_count_reg + 8'd1;
            end
        end
    end

`ifdef RAM_WR_SEQ_VERIFY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= 2'd0;
            err_reg     <= 1'b0;
            err_any_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            if (complete) begin
                err_reg     <= mismatch;
                err_any_reg <= err_any_reg | mismatch;
            end
        end
    end

    assign err     = err_reg;
    assign err_any = err_any_reg;
`else
    logic unused_rdata;
    assign unused_rdata = ^ram_rdata;
    assign err          = 1'b0;
    assign err_any      = 1'b0;
`endif

    // Address and data come straight from the capture registers, so they hold in IDLE/HOLD.
    assign ram_we    = (state_reg == ST_WRITE);
    assign ram_addr  = cap_addr_reg;
    assign ram_wdata = cap_data_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = done_reg;
    assign wr_count  = wr_count_reg;

endmodule
